// File: rtl/bird_move_ctrl.sv
// -----------------------------------------------------------------------------
// bird_move_ctrl
//   Game controller for the bird column. It synchronizes the raw player key,
//   turns it into single-cycle presses, and runs the IDLE / PLAY / DEAD game
//   state machine that issues flap (move up) and fall (gravity) pulses to
//   every cell of the bird column.
//
// Parameters
//   FALL_PERIOD  clock cycles between gravity ticks while playing (2..65535)
//
// Ports
//   clk         in   system clock, all state on the rising edge
//   reset_n     in   asynchronous active-low reset
//   key         in   raw player button (high = pressed), asynchronous to clk
//   collide     in   bird/pipe overlap flag from the playfield
//   top_lit     in   bird occupies the top row
//   bottom_lit  in   bird occupies the bottom row
//   flap        out  one-cycle move-up pulse
//   fall        out  one-cycle move-down pulse
//   playing     out  high while in PLAY
//   dead        out  high while in DEAD
// -----------------------------------------------------------------------------
module bird_move_ctrl #(
    parameter int unsigned FALL_PERIOD = 32
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key,
    input  logic collide,
    input  logic top_lit,
    input  logic bottom_lit,
    output logic flap,
    output logic fall,
    output logic playing,
    output logic dead
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_DEAD = 2'd2
    } state_e;

    localparam logic [15:0] TERM_CNT = 16'(FALL_PERIOD - 1);

    // ------------------------------------------------------------------
    // Key synchronizer and press detection
    // ------------------------------------------------------------------
    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    // vld*_q track how far real key samples have travelled down the
    // synchronizer since reset, so reset values are never mistaken for
    // a released key.
    logic       vld1_q, vld1_d;
    logic       vld2_q, vld2_d;
    // Consecutive real low samples of the synchronized key, saturating
    // at 2. A press needs two lows before the rising edge, which also
    // means a key held through reset release never produces a press.
    logic [1:0] lowrun_q, lowrun_d;
    logic       press;

    always_comb begin
        sync1_d = key;
        sync2_d = sync1_q;
        vld1_d  = 1'b1;
        vld2_d  = vld1_q;
        if (vld2_q && !sync2_q) begin
            lowrun_d = (lowrun_q == 2'd2) ? 2'd2 : lowrun_q + 2'd1;
        end else begin
            lowrun_d = 2'd0;
        end
    end

    // One cycle wide: once sync2_q is high the low run clears next edge.
    assign press = vld2_q && sync2_q && (lowrun_q == 2'd2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            vld1_q   <= 1'b0;
            vld2_q   <= 1'b0;
            lowrun_q <= 2'd0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            vld1_q   <= vld1_d;
            vld2_q   <= vld2_d;
            lowrun_q <= lowrun_d;
        end
    end

    // ------------------------------------------------------------------
    // Game FSM, gravity counter and registered outputs
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        flap_q, flap_d;
    logic        fall_q, fall_d;
    logic        playing_q, playing_d;
    logic        dead_q, dead_d;
    logic        term;

    assign term = (cnt_q == TERM_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        flap_d  = 1'b0;
        fall_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                if (press) begin
                    state_d = S_PLAY;
                end
            end

            S_PLAY: begin
                // Priority: collision, then an accepted flap, then gravity.
                if (collide) begin
                    state_d = S_DEAD;
                    cnt_d   = 16'd0;
                end else if (press && !top_lit) begin
                    flap_d = 1'b1;
                    cnt_d  = 16'd0;
                end else if (term) begin
                    cnt_d = 16'd0;
                    if (bottom_lit) begin
                        state_d = S_DEAD;
                    end else begin
                        fall_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_DEAD: begin
                cnt_d = 16'd0;
                if (press) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // Status flags are registered copies of the next state so they
        // carry no combinational path from the inputs.
        playing_d = (state_d == S_PLAY);
        dead_d    = (state_d == S_DEAD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            flap_q    <= 1'b0;
            fall_q    <= 1'b0;
            playing_q <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flap_q    <= flap_d;
            fall_q    <= fall_d;
            playing_q <= playing_d;
            dead_q    <= dead_d;
        end
    end

    assign flap    = flap_q;
    assign fall    = fall_q;
    assign playing = playing_q;
    assign dead    = dead_q;

endmodule
